kbd_cmd_ascii_tx: RTL
=====================

Name: kbd_cmd_ascii_tx

Overview:
- Reverse direction of the keyboard command decoder.
- Takes player-control command events (D, E, B, F, R) raised inside the design.
- Encodes each event to its ASCII byte and buffers it in a small FIFO.
- Serializes the bytes out as 8N1 UART, so the controlling terminal gets an echo/acknowledge of every command.
- Sits between the control FSM and the board's UART TX pin.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); legal range 4..65535.
- FIFO_DEPTH, 4, entries in the byte FIFO; power of two, 2..16.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  single-cycle strobe; cmd is sampled when high.
- cmd  input  5  one-hot command, bit0=D, bit1=E, bit2=B, bit3=F, bit4=R.
- lowercase  input  1  sampled with cmd_valid: 1 encodes 'd','e','b','f','r'; 0 encodes 'D','E','B','F','R'.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- tx_done  output  1  one-cycle pulse on the last cycle of each stop bit.
- overflow  output  1  one-cycle pulse when an accepted strobe is dropped because the FIFO is full.
- multi_hit  output  1  one-cycle pulse when cmd_valid arrives with more than one cmd bit set.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - tx=1, busy=0, tx_done=0, overflow=0, multi_hit=0.
  - FIFO emptied, bit counter and baud counter zeroed, FSM in IDLE.
  - Any partial frame is abandoned. The line returns high immediately; no glitch below high after reset asserts.
- Encode, same cycle as cmd_valid:
  - Priority D>E>B>F>R. Only the highest-priority set bit is encoded; other bits are discarded.
  - multi_hit pulses the next cycle if popcount(cmd)>1.
  - Uppercase codes: D=0x44, E=0x45, B=0x42, F=0x46, R=0x52. Lowercase = uppercase | 0x20.
  - cmd_valid with cmd==0: ignored, no push, no pulses.
- FIFO push:
  - Encoded byte is written on the clock edge where cmd_valid=1.
  - If the FIFO is full and no pop occurs that same edge, the byte is dropped and overflow pulses the next cycle.
  - Push and pop on the same edge while full: push accepted, occupancy unchanged.
  - Push and pop on the same edge while empty: cannot occur (pop requires non-empty).
- FSM states IDLE, START, DATA, STOP:
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, go to START, baud counter=0.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[bit index], LSB first, CLKS_PER_BIT cycles per bit. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. tx_done pulses on the final cycle. Next state is IDLE.
  - IDLE lasts exactly one cycle between back-to-back frames, so there is a 1-cycle gap when the FIFO is non-empty.
- Latency: strobe at edge N → byte in FIFO after edge N → popped at edge N+1 → tx falls at edge N+1 (start bit begins). Total frame length is 10*CLKS_PER_BIT cycles.
- busy = (state!=IDLE) | fifo_not_empty.
- Baud counter width is clog2(CLKS_PER_BIT). It wraps to 0 at CLKS_PER_BIT-1; no drift across frames.
- FIFO pointers are clog2(FIFO_DEPTH)+1 bits wide. The extra MSB distinguishes full from empty; pointers wrap naturally.

Decomposition:
- Package kbd_ascii_pkg:
  - ASCII constants for the command letters, digits and punctuation.
  - Command bit-index localparams (CMD_D=0 … CMD_R=4).
  - Enum tx_state_t {IDLE, START, DATA, STOP}.
  - Function cmd_to_ascii(cmd, lowercase) returning the 8-bit code.
- One sub-module, uart_tx_8n1:
  - Contains the FSM, baud counter and shift register.
  - Interface: data/valid/ready in; tx, tx_done out.
- The top level holds the encoder, the FIFO and the pulse flags.

Test Plan:
- Reset, then cmd_valid with cmd=5'b00010, lowercase=0, CLKS_PER_BIT=4 → tx falls 1 cycle later. Line carries 0,1,0,1,0,0,0,1,0,1 (start, 0x45 LSB-first, stop), 4 cycles each. tx_done pulses once and busy drops the cycle after.
- cmd=5'b00001, lowercase=1 → byte 0x64 ('d') serialized. cmd=5'b10000, lowercase=0 → 0x52.
- cmd=5'b01101 → 0x44 sent, multi_hit pulses once, only one frame emitted.
- Six strobes in consecutive cycles with FIFO_DEPTH=4: first is popped immediately, next four are queued, sixth → overflow pulse. Exactly 5 frames emitted in order, each separated by a 1-cycle high gap.
- Assert reset_n=0 during bit 3 of a frame with 2 bytes queued → tx=1 asynchronously, busy=0. After release, no further frames are emitted.
- cmd_valid with cmd=0 → no frame, no pulses, busy stays 0.

Source files
------------

// File: rtl/kbd_ascii_pkg.sv
// Shared constants, transmitter state type and command encoder for the
// keyboard command echo path.
package kbd_ascii_pkg;

  // Command letters (uppercase); lowercase is formed by setting the case bit.
  localparam logic [7:0] ASCII_D        = 8'h44;
  localparam logic [7:0] ASCII_E        = 8'h45;
  localparam logic [7:0] ASCII_B        = 8'h42;
  localparam logic [7:0] ASCII_F        = 8'h46;
  localparam logic [7:0] ASCII_R        = 8'h52;
  localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

  // Digits and punctuation used by neighbouring terminal logic.
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_NUL   = 8'h00;

  // Bit positions inside the one-hot command vector.
  localparam int CMD_D = 0;
  localparam int CMD_E = 1;
  localparam int CMD_B = 2;
  localparam int CMD_F = 3;
  localparam int CMD_R = 4;
  localparam int CMD_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Highest-priority set bit wins (D > E > B > F > R); no bit set gives NUL.
  function automatic logic [7:0] cmd_to_ascii(input logic [CMD_W-1:0] cmd,
                                              input logic lowercase);
    logic [7:0] upper_s;
    if (cmd[CMD_D])      upper_s = ASCII_D;
    else if (cmd[CMD_E]) upper_s = ASCII_E;
    else if (cmd[CMD_B]) upper_s = ASCII_B;
    else if (cmd[CMD_F]) upper_s = ASCII_F;
    else if (cmd[CMD_R]) upper_s = ASCII_R;
    else                 upper_s = ASCII_NUL;
    if (lowercase && (upper_s != ASCII_NUL)) return upper_s | ASCII_CASE_BIT;
    else                                     return upper_s;
  endfunction

endpackage

// File: rtl/kbd_cmd_ascii_tx_uart_tx_8n1.sv
// 8N1 UART transmitter: accepts a byte when idle, sends start, 8 data bits
// LSB first and a stop bit, each CLKS_PER_BIT cycles long.
module uart_tx_8n1
  import kbd_ascii_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       tx_done,
  output logic       active_next
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  tx_state_t   state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [2:0]  idx_r, idx_s;
  logic [7:0]  shift_r, shift_s;
  logic        tx_r, tx_s;
  logic        done_r, done_s;
  logic        last_s;

  assign last_s      = (cnt_r == CNT_MAX);
  assign ready       = (state_r == IDLE);
  assign active_next = (state_s != IDLE);
  assign tx          = tx_r;
  assign tx_done     = done_r;

  // Next-state logic: frame sequencing, baud counting and bit indexing.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    shift_s = shift_r;
    case (state_r)
      IDLE: begin
        if (valid) begin
          shift_s = data;
          state_s = START;
          cnt_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (last_s) begin
          state_s = DATA;
          cnt_s   = '0;
          idx_s   = 3'd0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      DATA: begin
        if (last_s) begin
          cnt_s = '0;
          if (idx_r == 3'd7) begin
            state_s = STOP;
            idx_s   = 3'd0;
          end else begin
            idx_s = idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      STOP: begin
        if (last_s) begin
          state_s = IDLE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        idx_s   = 3'd0;
      end
    endcase
  end

  // Output values for the next cycle, so tx and tx_done come straight from flops.
  always_comb begin
    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[idx_s];
      STOP:    tx_s = 1'b1;
      IDLE:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
    done_s = (state_s == STOP) && (cnt_s == CNT_MAX);
  end

  // State and output registers; reset drives the line high at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
      tx_r    <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      done_r  <= done_s;
    end
  end

endmodule

// File: rtl/kbd_cmd_ascii_tx.sv
// Command echo top: encodes command strobes to ASCII, queues them in a small
// FIFO and hands them to the 8N1 transmitter.
module kbd_cmd_ascii_tx
  import kbd_ascii_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  input  logic [4:0] cmd,
  input  logic       lowercase,
  output logic       tx,
  output logic       busy,
  output logic       tx_done,
  output logic       overflow,
  output logic       multi_hit
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  mem_r [FIFO_DEPTH];
  logic [AW:0] wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
  logic        empty_s, full_s, push_req_s, push_s, pop_s;
  logic        ready_s, active_next_s, multi_s, busy_s;
  logic [7:0]  byte_s;
  logic        busy_r, overflow_r, multi_hit_r;

  assign byte_s     = cmd_to_ascii(cmd, lowercase);
  assign empty_s    = (wr_ptr_r == rd_ptr_r);
  assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign push_req_s = cmd_valid && (cmd != 5'b00000);
  assign pop_s      = ready_s && !empty_s;
  assign push_s     = push_req_s && (!full_s || pop_s);
  assign multi_s    = cmd_valid && ((cmd & (cmd - 5'd1)) != 5'b00000);

  assign busy      = busy_r;
  assign overflow  = overflow_r;
  assign multi_hit = multi_hit_r;

  // Pointer advance and the busy value the flags will hold after this edge.
  always_comb begin
    wr_ptr_s = wr_ptr_r;
    rd_ptr_s = rd_ptr_r;
    if (push_s) wr_ptr_s = wr_ptr_r + PTR_ONE;
    else        wr_ptr_s = wr_ptr_r;
    if (pop_s)  rd_ptr_s = rd_ptr_r + PTR_ONE;
    else        rd_ptr_s = rd_ptr_r;
    busy_s = active_next_s || (wr_ptr_s != rd_ptr_s);
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 8'h00;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= byte_s;
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
    end
  end

  // Status flags: busy level plus one-cycle overflow and multi-hit pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r      <= 1'b0;
      overflow_r  <= 1'b0;
      multi_hit_r <= 1'b0;
    end else begin
      busy_r      <= busy_s;
      overflow_r  <= push_req_s && full_s && !pop_s;
      multi_hit_r <= multi_s;
    end
  end

  uart_tx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk         (clk),
    .reset_n     (reset_n),
    .data        (mem_r[rd_ptr_r[AW-1:0]]),
    .valid       (!empty_s),
    .ready       (ready_s),
    .tx          (tx),
    .tx_done     (tx_done),
    .active_next (active_next_s)
  );

endmodule
